accum_scratchpad: RTL
=====================

# accum_scratchpad

Parametrised successor to the single-port-pair scratchpad for the aggregation engine. Each row holds PARALLELISM signed lanes. Writes either overwrite a row or saturating-accumulate into it. The read port is registered, with a valid strobe. An internal sweep FSM zeroes the whole array after reset or on request. The block sits between the aggregation datapath (write/accumulate side) and the output drain logic (read side).

## Interface
Parameters:
- WIDTH, 8, bits per signed lane
- PARALLELISM, 1, lanes per row; row width = PARALLELISM*WIDTH
- HEIGHT, 128, rows; power of two ≥ 2; AW = $clog2(HEIGHT)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- CS  in  1  chip select; gates every read and write
- read_addr  in  AW  read row
- read_en  in  1  read request
- qout  out  PARALLELISM*WIDTH  registered read data
- q_valid  out  1  qout holds data for a request issued the previous cycle
- write_addr  in  AW  write row
- write_en  in  1  write request
- acc_mode  in  1  0 = overwrite, 1 = accumulate
- din  in  PARALLELISM*WIDTH  write/accumulate operand, signed per lane
- clear_start  in  1  one-cycle pulse; starts a full-array zero sweep
- busy  out  1  sweep in progress
- sat_flag  out  1  sticky; some lane saturated since last sweep start

## Operation
- FSM states: IDLE and CLEAR. A sweep pointer clr_ptr (AW bits) drives CLEAR.
- Reset enters CLEAR with clr_ptr=0.
- IDLE→CLEAR on clear_start. CS is not required for this. clr_ptr is reset to 0 and sat_flag is cleared on the same edge.
- In CLEAR, row clr_ptr is written to 0 each cycle and clr_ptr increments.
- After row HEIGHT-1 is written, the FSM returns to IDLE. clr_ptr wraps to 0.
- clear_start during CLEAR restarts the sweep at row 0.
- Overwrite (IDLE, CS & write_en & !acc_mode): data[write_addr] ← din.
- Accumulate (IDLE, CS & write_en & acc_mode): per lane, data ← sat(data + din).
  - The sum is computed at WIDTH+1 bits.
  - It clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Any clamped lane sets sat_flag.
- Read (CS & read_en): qout ← data[read_addr], q_valid ← 1. Otherwise qout ← 0 and q_valid ← 0.
- Read-during-write to the same row is read-first: the read returns the pre-write contents.
- During CLEAR, writes are dropped. Reads still complete, but qout is forced to 0 because array contents are undefined until the sweep passes.
- The array itself is not reset. Only the FSM, clr_ptr, qout, q_valid and sat_flag are.

## Timing
- Reset values: qout=0, q_valid=0, busy=1, sat_flag=0.
- Read latency is 1 cycle. A request at edge t gives qout/q_valid valid after edge t+1.
- One read per cycle is sustained.
- Write/accumulate takes effect at the sampling edge. A read issued the next cycle sees the new value.
- Back-to-back accumulates to the same row are legal every cycle. Each one sees the previous result; there is no stall.
- A sweep takes exactly HEIGHT cycles. busy drops on the edge after row HEIGHT-1 is written. A write in the first cycle with busy=0 is accepted.
- rst_n asserted mid-sweep or mid-operation takes effect immediately on outputs. The sweep restarts at row 0 on release.
- A write and a read may both occur in one cycle. A write and clear_start in the same cycle: clear wins and the write is dropped.

## Structure
- Package scratchpad_pkg holds:
  - state typedef (IDLE, CLEAR)
  - acc_mode localparams MODE_OVERWRITE=0, MODE_ACCUMULATE=1
  - helper function for saturation bounds from WIDTH
- Sub-module sat_lane_add holds one lane's WIDTH+1-bit add, clamp and overflow flag. It is combinational and instantiated PARALLELISM times in a generate loop.
- Top level holds the array, FSM, read register and sat_flag.

## Test plan
- Reset release, HEIGHT=8: busy=1 for exactly 8 cycles, then 0. Reading any row afterwards → qout=0, q_valid=1 one cycle later.
- WIDTH=8, PARALLELISM=2: overwrite row 3 with {8'sd10, -8'sd5}, then accumulate {8'sd20, -8'sd7} → read row 3 = {30, -12}, sat_flag=0.
- Accumulate 8'sd100 three times into row 0 (start 0) → 100, 127, 127. sat_flag rises after the second accumulate. Then add -8'sd128 twice → -1, -128.
- Same-cycle write row 5 = 0x55 and read row 5 (old value 0x11) → qout=0x11. Next-cycle read → 0x55.
- clear_start with row 2 = 0x7F, plus a write to row 4 during busy → both rows read 0 after the sweep, sat_flag=0.
- rst_n pulse mid-sweep at row 4 → outputs reset immediately. The sweep restarts at row 0 and takes a full HEIGHT cycles after release.

Source files
------------

// File: rtl/scratchpad_pkg.sv
// Shared types, write-mode encodings and saturation-bound helpers for the
// accumulating scratchpad.
package scratchpad_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic MODE_OVERWRITE  = 1'b0;
  localparam logic MODE_ACCUMULATE = 1'b1;

  // Largest positive value of a w-bit two's complement lane
  function automatic int sat_max(input int unsigned w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Most negative value of a w-bit two's complement lane
  function automatic int sat_min(input int unsigned w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/sat_lane_add.sv
// One signed lane: WIDTH+1-bit add, clamp to the WIDTH-bit range, flag on clamp.
module sat_lane_add
  import scratchpad_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum_c,
  output logic             o_ovf_c
);

  localparam logic [WIDTH-1:0] LANE_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] LANE_MIN = WIDTH'(sat_min(WIDTH));

  logic [WIDTH:0] w_sum;

  assign w_sum = {i_a[WIDTH-1], i_a} + {i_b[WIDTH-1], i_b};

  // Top two bits disagree only when the true sum leaves the WIDTH-bit range
  always_comb begin
    o_sum_c = w_sum[WIDTH-1:0];
    o_ovf_c = 1'b0;
    if (w_sum[WIDTH] != w_sum[WIDTH-1]) begin
      o_ovf_c = 1'b1;
      o_sum_c = w_sum[WIDTH] ? LANE_MIN : LANE_MAX;
    end
  end

endmodule

// File: rtl/accum_scratchpad.sv
// Row-addressed scratchpad with overwrite / saturating-accumulate writes,
// registered read port and a zeroing sweep after reset or on request.
module accum_scratchpad
  import scratchpad_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned PARALLELISM = 1,
  parameter int unsigned HEIGHT      = 128
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             CS,
  input  logic [$clog2(HEIGHT)-1:0]        read_addr,
  input  logic                             read_en,
  output logic [PARALLELISM*WIDTH-1:0]     qout,
  output logic                             q_valid,
  input  logic [$clog2(HEIGHT)-1:0]        write_addr,
  input  logic                             write_en,
  input  logic                             acc_mode,
  input  logic [PARALLELISM*WIDTH-1:0]     din,
  input  logic                             clear_start,
  output logic                             busy,
  output logic                             sat_flag
);

  localparam int unsigned AW = $clog2(HEIGHT);
  localparam int unsigned RW = PARALLELISM * WIDTH;
  localparam logic [AW-1:0] LAST_ROW = AW'(HEIGHT - 1);

  logic [RW-1:0]          r_mem [HEIGHT];
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [AW-1:0]          r_clr_ptr;
  logic [AW-1:0]          w_clr_ptr_nxt;
  logic [RW-1:0]          r_qout;
  logic                   r_q_valid;
  logic                   r_busy;
  logic                   r_sat_flag;
  logic [RW-1:0]          w_old_row;
  logic [RW-1:0]          w_acc_row;
  logic [PARALLELISM-1:0] w_lane_ovf;
  logic                   w_wr_ok;
  logic                   w_rd_ok;
  logic                   w_is_acc;

  assign w_old_row = r_mem[write_addr];
  assign w_is_acc  = (acc_mode == MODE_ACCUMULATE);
  // A clear request in the same cycle pre-empts any write
  assign w_wr_ok   = (r_state == IDLE) && !clear_start && CS && write_en;
  assign w_rd_ok   = CS && read_en;

  for (genvar g = 0; g < PARALLELISM; g++) begin : g_lane
    sat_lane_add #(
      .WIDTH (WIDTH)
    ) u_sat_lane_add (
      .i_a     (w_old_row[g*WIDTH +: WIDTH]),
      .i_b     (din[g*WIDTH +: WIDTH]),
      .o_sum_c (w_acc_row[g*WIDTH +: WIDTH]),
      .o_ovf_c (w_lane_ovf[g])
    );
  end

  // Sweep sequencing
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    if (clear_start) begin
      w_state_nxt   = CLEAR;
      w_clr_ptr_nxt = '0;
    end else if (r_state == CLEAR) begin
      w_clr_ptr_nxt = r_clr_ptr + AW'(1);
      if (r_clr_ptr == LAST_ROW) begin
        w_state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= CLEAR;
      r_clr_ptr  <= '0;
      r_busy     <= 1'b1;
      r_qout     <= '0;
      r_q_valid  <= 1'b0;
      r_sat_flag <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
      r_busy    <= (w_state_nxt == CLEAR);
      r_q_valid <= w_rd_ok;
      // Contents are not trustworthy until the sweep has passed, so read zero
      r_qout    <= (w_rd_ok && (r_state == IDLE)) ? r_mem[read_addr] : '0;
      if (clear_start) begin
        r_sat_flag <= 1'b0;
      end else if (w_wr_ok && w_is_acc && (|w_lane_ovf)) begin
        r_sat_flag <= 1'b1;
      end
    end
  end

  // Storage array carries no reset; the sweep initialises it
  always_ff @(posedge clk) begin
    if (r_state == CLEAR) begin
      r_mem[r_clr_ptr] <= '0;
    end else if (w_wr_ok) begin
      r_mem[write_addr] <= w_is_acc ? w_acc_row : din;
    end
  end

  assign qout     = r_qout;
  assign q_valid  = r_q_valid;
  assign busy     = r_busy;
  assign sat_flag = r_sat_flag;

endmodule
